sink_table_writer: RTL and testbench
====================================

Name: sink_table_writer

Overview:
Builds the flattened known-sinks array consumed by the sink-matching and array-parsing logic. Sink IDs arrive serially over a valid/ready handshake. Each ID is checked against the current table by a serial scan, one slot per cycle, and appended only if it is new and a slot is free. It is the writer side of the flattened sink-table interface and replaces the ad-hoc loop-based table fill.

Parameters:
N_SLOTS, 10, number of table slots
ID_W, 5, bits per sink ID
EMPTY_ID, 31, marker stored in unused slots; never accepted as a valid ID
CNT_W, 4, width of sink_count (must hold N_SLOTS)

Ports:
clock  input  1  clock, rising edge
reset  input  1  reset, asynchronous, active-high
clear  input  1  synchronous table clear, highest priority after reset
in_valid  input  1  in_id is valid
in_id  input  ID_W  sink ID to insert
in_ready  output  1  block can accept an ID this cycle
known_sinks  output  N_SLOTS*ID_W  flattened table; slot i at bits [ID_W*i +: ID_W]
sink_count  output  CNT_W  number of valid slots
full  output  1  sink_count == N_SLOTS (combinational from registered count)
ack_pulse  output  1  one cycle: ID inserted
dup_pulse  output  1  one cycle: ID already present, table unchanged
rej_pulse  output  1  one cycle: ID rejected (table full or in_id == EMPTY_ID)

Behaviour:
- Reset (asynchronous):
  - all slots = EMPTY_ID; sink_count = 0; state = IDLE.
  - in_ready = 1; all pulse outputs = 0.
- States: IDLE, SCAN, RESP.
- IDLE:
  - in_ready = 1 (0 while clear is high).
  - A handshake occurs on a rising edge with in_valid & in_ready. At that edge (E0): latch in_id into id_q, set idx = 0.
  - If in_id == EMPTY_ID: result = REJ, go to RESP.
  - Otherwise go to SCAN.
- SCAN (in_ready = 0): one slot is examined per edge. At edge E(1+k), idx = k:
  - k < sink_count and slot[k] == id_q: result = DUP, go to RESP.
  - k < sink_count and no match: idx = k+1, stay in SCAN.
  - k == sink_count and sink_count < N_SLOTS: write slot[k] = id_q, increment sink_count, result = ACK, go to RESP. known_sinks and sink_count update on this edge.
  - k == sink_count and sink_count == N_SLOTS: result = REJ, go to RESP.
- RESP (in_ready = 0):
  - Exactly one of ack_pulse, dup_pulse or rej_pulse is high, for this single cycle, according to result.
  - Next edge returns to IDLE.
- Latency:
  - A new ID with count c before insertion holds in_ready low for c+2 cycles.
  - A duplicate found at slot j holds in_ready low for j+2 cycles.
  - An EMPTY_ID input holds in_ready low for 1 cycle.
- clear (synchronous, in any state):
  - Next edge: all slots = EMPTY_ID, sink_count = 0, state = IDLE.
  - No pulse is generated for an aborted operation.
  - clear overrides a simultaneous handshake; the ID is not accepted because in_ready is 0.
- Reset mid-operation: same as clear, but asynchronous.
- Table contents never reorder. Slots at index >= sink_count always hold EMPTY_ID.
- in_id is ignored outside the handshake edge. Changes to in_id during SCAN have no effect.
- Counters and indices never wrap: idx stops at sink_count, and sink_count saturates at N_SLOTS by construction.

Test Plan:
- Reset: assert reset, release -> known_sinks = 50'h3FFFFFFFFFFFF, sink_count = 0, full = 0, in_ready = 1, all pulses 0.
- Insert 3 then 7 -> known_sinks[4:0] = 3, [9:5] = 7, others 31, sink_count = 2. One ack_pulse each. in_ready low for 2 cycles, then 3 cycles.
- Insert 7 again into {3,7} -> dup_pulse in the 3rd cycle after the handshake, sink_count stays 2, known_sinks unchanged. Insert 3 -> dup_pulse after 2 cycles.
- Fill with IDs 0..9 -> full = 1, sink_count = 10, known_sinks[5*i +: 5] = i. Then insert 12 -> rej_pulse after 12 cycles, table unchanged.
- Insert in_id = 31 -> rej_pulse in the cycle after the handshake, sink_count unchanged, in_ready back after 1 cycle.
- Assert clear during the SCAN of the 6th insertion -> next cycle table all 31, sink_count = 0, state IDLE, no ack/dup/rej pulse. Repeat with reset pulsed mid-scan: same result, applied asynchronously.

Source files
------------

// File: rtl/sink_table_writer.sv
// Writer for the flattened known-sinks table: accepts sink IDs over valid/ready,
// scans the table one slot per cycle and appends IDs that are new while space remains.
module sink_table_writer #(
  parameter int unsigned N_SLOTS  = 10,
  parameter int unsigned ID_W     = 5,
  parameter int unsigned EMPTY_ID = 31,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic [ID_W-1:0]         in_id,
  output logic                    in_ready,
  output logic [N_SLOTS*ID_W-1:0] known_sinks,
  output logic [CNT_W-1:0]        sink_count,
  output logic                    full,
  output logic                    ack_pulse,
  output logic                    dup_pulse,
  output logic                    rej_pulse
);

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;
  typedef enum logic [1:0] {RES_ACK, RES_DUP, RES_REJ} result_t;

  localparam logic [ID_W-1:0]  EMPTY = ID_W'(EMPTY_ID);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(N_SLOTS);

  state_t          state_q, state_d;
  result_t         result_q, result_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ID_W-1:0] slots_q [N_SLOTS];
  logic [ID_W-1:0] slots_d [N_SLOTS];
  logic [ID_W-1:0] cur_slot;

  // State and table registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= RES_ACK;
      id_q     <= '0;
      idx_q    <= '0;
      count_q  <= '0;
      for (int i = 0; i < N_SLOTS; i++) slots_q[i] <= EMPTY;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      id_q     <= id_d;
      idx_q    <= idx_d;
      count_q  <= count_d;
      for (int i = 0; i < N_SLOTS; i++) slots_q[i] <= slots_d[i];
    end
  end

  // Slot currently under the scan pointer; the mux avoids indexing past the array
  always_comb begin
    cur_slot = EMPTY;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (CNT_W'(i) == idx_q) cur_slot = slots_q[i];
    end
  end

  // Next-state logic: handshake, serial scan, append and response
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    id_d     = id_q;
    idx_d    = idx_q;
    count_d  = count_q;
    for (int i = 0; i < N_SLOTS; i++) slots_d[i] = slots_q[i];

    if (clear) begin
      state_d = IDLE;
      count_d = '0;
      idx_d   = '0;
      for (int i = 0; i < N_SLOTS; i++) slots_d[i] = EMPTY;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            id_d  = in_id;
            idx_d = '0;
            if (in_id == EMPTY) begin
              result_d = RES_REJ;
              state_d  = RESP;
            end else begin
              state_d = SCAN;
            end
          end
        end
        SCAN: begin
          if (idx_q < count_q) begin
            if (cur_slot == id_q) begin
              result_d = RES_DUP;
              state_d  = RESP;
            end else begin
              idx_d = idx_q + CNT_W'(1);
            end
          end else if (count_q < MAX_C) begin
            for (int i = 0; i < N_SLOTS; i++) begin
              if (CNT_W'(i) == idx_q) slots_d[i] = id_q;
            end
            count_d  = count_q + CNT_W'(1);
            result_d = RES_ACK;
            state_d  = RESP;
          end else begin
            result_d = RES_REJ;
            state_d  = RESP;
          end
        end
        RESP: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Flatten the table for downstream matching logic
  always_comb begin
    known_sinks = '0;
    for (int i = 0; i < N_SLOTS; i++) known_sinks[ID_W*i +: ID_W] = slots_q[i];
  end

  assign in_ready   = (state_q == IDLE) && !clear;
  assign sink_count = count_q;
  assign full       = (count_q == MAX_C);
  assign ack_pulse  = (state_q == RESP) && (result_q == RES_ACK);
  assign dup_pulse  = (state_q == RESP) && (result_q == RES_DUP);
  assign rej_pulse  = (state_q == RESP) && (result_q == RES_REJ);

endmodule

// File: tb/tb_sink_table_writer.sv
// Directed bench for sink_table_writer: inserts, duplicates, rejects, clear and reset aborts.
module tb_sink_table_writer;

  localparam logic [49:0] ALL_EMPTY = 50'h3FFFFFFFFFFFF;

  logic        clock;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic [4:0]  in_id;
  logic        in_ready;
  logic [49:0] known_sinks;
  logic [3:0]  sink_count;
  logic        full;
  logic        ack_pulse;
  logic        dup_pulse;
  logic        rej_pulse;

  int total = 0;
  int bad   = 0;

  sink_table_writer dut (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_id      (in_id),
    .in_ready   (in_ready),
    .known_sinks(known_sinks),
    .sink_count (sink_count),
    .full       (full),
    .ack_pulse  (ack_pulse),
    .dup_pulse  (dup_pulse),
    .rej_pulse  (rej_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Handshake one ID, then watch until in_ready returns; kind 1=ack 2=dup 3=rej
  task automatic insert(input logic [4:0] id, output int lat, output int kind,
                        output int pcyc, output int npulse);
    int waited;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (!in_ready) check("ready_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_id    = id;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_id    = id ^ 5'h0A;
    lat = 0; kind = 0; pcyc = 0; npulse = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (ack_pulse) begin npulse++; kind = 1; pcyc = c; end
      if (dup_pulse) begin npulse++; kind = 2; pcyc = c; end
      if (rej_pulse) begin npulse++; kind = 3; pcyc = c; end
      if (in_ready) break;
      lat++;
    end
  endtask

  task automatic ins_chk(input string tag, input logic [4:0] id, input int exp_kind,
                         input int exp_lat);
    int lat, kind, pcyc, npulse;
    insert(id, lat, kind, pcyc, npulse);
    check({tag, "_kind"}, 64'(kind), 64'(exp_kind));
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_pcyc"}, 64'(pcyc), 64'(exp_lat));
    check({tag, "_npulse"}, 64'(npulse), 64'd1);
  endtask

  task automatic do_clear();
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    @(negedge clock);
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_table"}, 64'(known_sinks), 64'(ALL_EMPTY));
    check({tag, "_count"}, 64'(sink_count), 64'd0);
    check({tag, "_full"}, 64'(full), 64'd0);
    check({tag, "_ready"}, 64'(in_ready), 64'd1);
  endtask

  task automatic count_pulses(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clock);
      if (ack_pulse || dup_pulse || rej_pulse) n++;
    end
  endtask

  // Start an insertion of id and return at the negedge two cycles into its scan
  task automatic start_scan(input logic [4:0] id);
    in_valid = 1'b1;
    in_id    = id;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
  endtask

  initial begin
    logic [49:0] exp_tab;
    int n;
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_id = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    check_empty("reset");
    check("reset_pulses", 64'({ack_pulse, dup_pulse, rej_pulse}), 64'd0);

    // New IDs: latency count+2
    ins_chk("ins3", 5'd3, 1, 2);
    ins_chk("ins7", 5'd7, 1, 3);
    check("two_table", 64'(known_sinks), 64'(50'h3FFFFFFFFFCE3));
    check("two_count", 64'(sink_count), 64'd2);

    // Duplicates: latency slot+2, table unchanged
    ins_chk("dup7", 5'd7, 2, 3);
    ins_chk("dup3", 5'd3, 2, 2);
    check("dup_table", 64'(known_sinks), 64'(50'h3FFFFFFFFFCE3));
    check("dup_count", 64'(sink_count), 64'd2);

    // EMPTY_ID is always rejected after one cycle
    ins_chk("empty_id", 5'd31, 3, 1);
    check("empty_count", 64'(sink_count), 64'd2);
    check("empty_table", 64'(known_sinks), 64'(50'h3FFFFFFFFFCE3));

    do_clear();
    check_empty("clear");

    // Fill to capacity
    for (int i = 0; i < 10; i++) ins_chk($sformatf("fill%0d", i), 5'(i), 1, i + 2);
    exp_tab = '0;
    for (int i = 0; i < 10; i++) exp_tab[5*i +: 5] = 5'(i);
    check("full_flag", 64'(full), 64'd1);
    check("full_count", 64'(sink_count), 64'd10);
    check("full_table", 64'(known_sinks), 64'(exp_tab));

    ins_chk("rej_full", 5'd12, 3, 12);
    check("rej_full_table", 64'(known_sinks), 64'(exp_tab));
    check("rej_full_count", 64'(sink_count), 64'd10);
    ins_chk("dup_last", 5'd9, 2, 11);
    ins_chk("empty_full", 5'd31, 3, 1);
    check("after_full_table", 64'(known_sinks), 64'(exp_tab));

    // Clear during the sixth insertion's scan
    do_clear();
    for (int i = 0; i < 5; i++) ins_chk($sformatf("pre_clr%0d", i), 5'(i + 20), 1, i + 2);
    start_scan(5'd11);
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    @(negedge clock);
    check_empty("mid_clear");
    count_pulses(8, n);
    check("mid_clear_pulses", 64'(n), 64'd0);
    ins_chk("post_clear", 5'd11, 1, 2);

    // Reset during the sixth insertion's scan takes effect without a clock edge
    do_clear();
    for (int i = 0; i < 5; i++) ins_chk($sformatf("pre_rst%0d", i), 5'(i + 1), 1, i + 2);
    start_scan(5'd17);
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_table", 64'(known_sinks), 64'(ALL_EMPTY));
    check("async_rst_count", 64'(sink_count), 64'd0);
    check("async_rst_ready", 64'(in_ready), 64'd1);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check_empty("mid_reset");
    count_pulses(8, n);
    check("mid_reset_pulses", 64'(n), 64'd0);
    ins_chk("post_reset", 5'd17, 1, 2);
    check("post_reset_table", 64'(known_sinks[9:0]), 64'({5'd31, 5'd17}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
